// File: rtl/exu_seq_ctrl_pkg.sv
// rtl/exu_seq_ctrl_pkg.sv - shared state encoding and helpers for the NPC sequencer
package exu_seq_ctrl_pkg;

    localparam int ST_WIDTH = 3;

    typedef enum logic [ST_WIDTH-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT_I = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MREQ   = 3'd4,
        ST_MWAIT  = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } seq_state_e;

    // States that wait on an external handshake and are therefore watched.
    function automatic logic is_wait_state(input seq_state_e st);
        return (st == ST_FETCH) || (st == ST_WAIT_I) ||
               (st == ST_MREQ)  || (st == ST_MWAIT);
    endfunction

endpackage

// File: rtl/exu_seq_ctrl_watchdog.sv
// rtl/exu_seq_ctrl_watchdog.sv - handshake watchdog counter with clear/enable and expiry compare
module exu_seq_ctrl_watchdog #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Expiry fires in the cycle whose increment would make the count reach TIMEOUT,
    // so a wait of exactly TIMEOUT cycles is the last one tolerated.
    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT - 1);

    logic [TO_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/exu_seq_ctrl.sv
// rtl/exu_seq_ctrl.sv - multi-cycle fetch/execute/memory/commit sequencer for the NPC core
module exu_seq_ctrl
    import exu_seq_ctrl_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ifu_req_valid,
    input  logic                ifu_req_ready,
    input  logic                ifu_rsp_valid,
    input  logic [DATA_LEN-1:0] ifu_rsp_inst,
    output logic [DATA_LEN-1:0] inst,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                is_ebreak,
    output logic                lsu_req_valid,
    input  logic                lsu_req_ready,
    input  logic                lsu_rsp_valid,
    input  logic                pc_w_en_in,
    input  logic                gpr_w_en_in,
    output logic                pc_w_en,
    output logic                gpr_w_en,
    output logic                halted,
    output logic                bus_err,
    output logic [31:0]         inst_cnt
);

    seq_state_e          state;
    seq_state_e          state_nxt;
    logic                wd_expired;
    logic                timeout_hit;
    logic [DATA_LEN-1:0] inst_q;
    logic [31:0]         cnt_q;
    logic                bus_err_q;

    exu_seq_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_WIDTH(TO_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_nxt != state),
        .en     (is_wait_state(state)),
        .expired(wd_expired)
    );

    // A completing handshake takes priority over a simultaneous watchdog expiry.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        unique case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (ifu_req_ready) begin
                    state_nxt = ST_WAIT_I;
                end else if (wd_expired) begin
                    state_nxt   = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT_I: begin
                if (ifu_rsp_valid) begin
                    state_nxt = ST_EXEC;
                end else if (wd_expired) begin
                    state_nxt   = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_EXEC: state_nxt = (is_load || is_store) ? ST_MREQ : ST_WB;
            ST_MREQ: begin
                if (lsu_req_ready) begin
                    state_nxt = ST_MWAIT;
                end else if (wd_expired) begin
                    state_nxt   = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_MWAIT: begin
                if (lsu_rsp_valid) begin
                    state_nxt = ST_WB;
                end else if (wd_expired) begin
                    state_nxt   = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WB:   state_nxt = is_ebreak ? ST_HALT : ST_FETCH;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            inst_q    <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT_I && ifu_rsp_valid) begin
                inst_q <= ifu_rsp_inst;
            end
            if (state == ST_WB) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Write enables only pass through in WB so PC/GPR update once per retire.
    assign ifu_req_valid = (state == ST_FETCH);
    assign lsu_req_valid = (state == ST_MREQ);
    assign pc_w_en       = (state == ST_WB) && pc_w_en_in;
    assign gpr_w_en      = (state == ST_WB) && gpr_w_en_in;
    assign halted        = (state == ST_HALT);
    assign bus_err       = bus_err_q;
    assign inst          = inst_q;
    assign inst_cnt      = cnt_q;

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// tb/tb_exu_seq_ctrl.sv - scoreboard bench for exu_seq_ctrl with a tiny decoder and bus models
module tb_exu_seq_ctrl;

    localparam logic [31:0] ADDI1  = 32'h0050_0093;
    localparam logic [31:0] ADDI2  = 32'h0010_8113;
    localparam logic [31:0] LW     = 32'h0000_A103;
    localparam logic [31:0] SW     = 32'h0020_A223;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst, inst;
    logic        is_load, is_store, is_ebreak;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        pc_w_en_in, gpr_w_en_in, pc_w_en, gpr_w_en;
    logic        halted, bus_err;
    logic [31:0] inst_cnt;

    always #5 clk = ~clk;

    exu_seq_ctrl #(.DATA_LEN(32), .TIMEOUT(8), .TO_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst (ifu_rsp_inst),
        .inst         (inst),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_ebreak    (is_ebreak),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .pc_w_en_in   (pc_w_en_in),
        .gpr_w_en_in  (gpr_w_en_in),
        .pc_w_en      (pc_w_en),
        .gpr_w_en     (gpr_w_en),
        .halted       (halted),
        .bus_err      (bus_err),
        .inst_cnt     (inst_cnt)
    );

    // Stand-in for the real decoder; raw pc_w_en_in is always high so gating is exercised.
    assign is_load     = (inst[6:0] == 7'h03);
    assign is_store    = (inst[6:0] == 7'h23);
    assign is_ebreak   = (inst == EBREAK);
    assign gpr_w_en_in = (inst[6:0] == 7'h13) || (inst[6:0] == 7'h03);
    assign pc_w_en_in  = 1'b1;

    typedef struct {
        logic        gpr;
        logic [31:0] word;
        logic [31:0] cnt;
    } commit_t;

    commit_t     exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic exp_gpr(input logic [31:0] w);
        return (w[6:0] == 7'h13) || (w[6:0] == 7'h03);
    endfunction

    function automatic logic is_mem(input logic [31:0] w);
        return (w[6:0] == 7'h03) || (w[6:0] == 7'h23);
    endfunction

    // Monitor: every write-enable pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (pc_w_en || gpr_w_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got pc=%0b gpr=%0b inst=0x%08h expected no commit",
                         pc_w_en, gpr_w_en, inst);
            end else begin
                commit_t e;
                e = exp_q.pop_front();
                chk("commit_pc_w_en", 32'(pc_w_en), 32'd1);
                chk("commit_gpr_w_en", 32'(gpr_w_en), 32'(e.gpr));
                chk("commit_inst", inst, e.word);
                chk("commit_inst_cnt", inst_cnt, e.cnt);
            end
        end
    end

    task automatic wait_ifu();
        int n = 0;
        while (!ifu_req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ifu_req_valid) chk("ifu_req_timeout", 32'(ifu_req_valid), 32'd1);
    endtask

    task automatic wait_lsu();
        int n = 0;
        while (!lsu_req_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!lsu_req_valid) chk("lsu_req_timeout", 32'(lsu_req_valid), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] w, input int rdly);
        wait_ifu();
        repeat (rdly) begin
            ifu_req_ready = 1'b0;
            @(negedge clk);
            chk("ifu_req_hold", 32'(ifu_req_valid), 32'd1);
        end
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = w;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        chk("inst_latch", inst, w);
    endtask

    task automatic do_mem(input int rdly);
        wait_lsu();
        repeat (rdly) begin
            lsu_req_ready = 1'b0;
            @(negedge clk);
            chk("lsu_req_hold", 32'(lsu_req_valid), 32'd1);
        end
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b1;
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic run_inst(input logic [31:0] w, input int ird, input int mrd);
        commit_t e;
        e.gpr  = exp_gpr(w);
        e.word = w;
        e.cnt  = model_cnt;
        exp_q.push_back(e);
        model_cnt = model_cnt + 32'd1;
        do_fetch(w, ird);
        if (is_mem(w)) do_mem(mrd);
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        repeat (n) @(negedge clk);
        model_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        int n;
        // Reset values and the single IDLE bubble.
        do_reset(3);
        chk("rst_ifu_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("rst_lsu_req_valid", 32'(lsu_req_valid), 32'd0);
        chk("rst_pc_w_en", 32'(pc_w_en), 32'd0);
        chk("rst_gpr_w_en", 32'(gpr_w_en), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_cnt", inst_cnt, 32'd0);
        rst = 1'b1;
        chk("idle_bubble", 32'(ifu_req_valid), 32'd0);
        @(negedge clk);
        chk("first_fetch", 32'(ifu_req_valid), 32'd1);

        // Zero-wait ALU op, then memory ops with handshake stalls.
        run_inst(ADDI1, 0, 0);
        wait_ifu();
        chk("cnt_after_addi", inst_cnt, 32'd1);
        run_inst(LW, 0, 4);
        run_inst(SW, 2, 1);
        run_inst(ADDI2, 1, 0);
        wait_ifu();
        chk("cnt_after_four", inst_cnt, 32'd4);

        // ebreak retires once, then the core ignores all bus traffic.
        run_inst(EBREAK, 0, 0);
        n = 0;
        while (!halted && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ebreak_halted", 32'(halted), 32'd1);
        chk("ebreak_no_bus_err", 32'(bus_err), 32'd0);
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = ADDI1;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_no_fetch", 32'(ifu_req_valid), 32'd0);
            chk("halt_cnt_frozen", inst_cnt, model_cnt);
        end
        chk("halt_sticky", 32'(halted), 32'd1);

        // Instruction response never arrives: watchdog expires after 8 WAIT_I cycles.
        do_reset(2);
        rst = 1'b1;
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_bus_err", 32'(bus_err), 32'd0);
        chk("rst2_inst_cnt", inst_cnt, 32'd0);
        wait_ifu();
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        n = 0;
        while (!halted && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_wait_cycles", 32'(n), 32'd8);
        chk("timeout_bus_err", 32'(bus_err), 32'd1);
        chk("timeout_halted", 32'(halted), 32'd1);
        chk("timeout_no_commit", inst_cnt, 32'd0);

        // Reset while a load waits for its response.
        do_reset(2);
        rst = 1'b1;
        run_inst(ADDI1, 0, 0);
        do_fetch(LW, 0);
        wait_lsu();
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        chk("mwait_cnt_before_rst", inst_cnt, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ifu_req_valid", 32'(ifu_req_valid), 32'd0);
        chk("abort_lsu_req_valid", 32'(lsu_req_valid), 32'd0);
        chk("abort_pc_w_en", 32'(pc_w_en), 32'd0);
        chk("abort_gpr_w_en", 32'(gpr_w_en), 32'd0);
        chk("abort_inst", inst, 32'd0);
        chk("abort_inst_cnt", inst_cnt, 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        chk("abort_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        chk("abort_idle_bubble", 32'(ifu_req_valid), 32'd0);
        @(negedge clk);
        chk("abort_refetch", 32'(ifu_req_valid), 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
